// File: rtl/alu_arbiter_if.sv
// Requester-side bundle of the ALU arbiter: two request/response handshake
// ports plus the shared result bus.
interface alu_arbiter_if #(
  parameter int WORD_SIZE = 16
);
  logic                 req0_valid;
  logic                 req0_ready;
  logic [WORD_SIZE-1:0] req0_a;
  logic [WORD_SIZE-1:0] req0_b;
  logic [2:0]           req0_func;

  logic                 req1_valid;
  logic                 req1_ready;
  logic [WORD_SIZE-1:0] req1_a;
  logic [WORD_SIZE-1:0] req1_b;
  logic [2:0]           req1_func;

  logic                 resp0_valid;
  logic                 resp0_ready;
  logic                 resp1_valid;
  logic                 resp1_ready;
  logic [WORD_SIZE-1:0] resp_data;
  logic                 resp_overflow;

  // Requester view: issues operations, consumes results.
  modport master (
    output req0_valid, req0_a, req0_b, req0_func,
    output req1_valid, req1_a, req1_b, req1_func,
    output resp0_ready, resp1_ready,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp1_valid, resp_data, resp_overflow
  );

  // Arbiter view.
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_func,
    input  req1_valid, req1_a, req1_b, req1_func,
    input  resp0_ready, resp1_ready,
    output req0_ready, req1_ready,
    output resp0_valid, resp1_valid, resp_data, resp_overflow
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters:
// accept one op, drive the ALU for one cycle, hold the result until consumed.
module alu_arbiter #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  alu_arbiter_if.slave         bus,
  output logic [WORD_SIZE-1:0] alu_a,
  output logic [WORD_SIZE-1:0] alu_b,
  output logic [2:0]           alu_func,
  input  logic [WORD_SIZE-1:0] alu_c,
  input  logic                 alu_overflow,
  output logic                 busy,
  output logic                 grant_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    FN_ADD = 3'd0,
    FN_SUB = 3'd1,
    FN_AND = 3'd2,
    FN_OR  = 3'd3,
    FN_NOT = 3'd4,
    FN_NEG = 3'd5,
    FN_SHL = 3'd6,
    FN_ASR = 3'd7
  } func_t;

  state_t               state;
  state_t               next_state;
  logic                 last_grant;
  logic                 winner;
  logic                 accept;
  logic                 resp_take;
  logic                 arith_op;
  logic [WORD_SIZE-1:0] resp_data_q;
  logic                 resp_overflow_q;

  // Round-robin pick; only meaningful while at least one valid is high.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    winner = 1'b0;
    unique case ({bus.req1_valid, bus.req0_valid})
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_grant;
      default: winner = 1'b0;
    endcase
  end

  // Ready is gated by reset_n so an asserted reset silences every output.
  assign bus.req0_ready = reset_n && (state == IDLE) && bus.req0_valid && !winner;
  assign bus.req1_ready = reset_n && (state == IDLE) && bus.req1_valid &&  winner;
  assign accept         = bus.req0_ready || bus.req1_ready;

  assign resp_take = grant_id ? bus.resp1_ready : bus.resp0_ready;

  assign bus.resp0_valid   = (state == DONE) && !grant_id;
  assign bus.resp1_valid   = (state == DONE) &&  grant_id;
  assign bus.resp_data     = resp_data_q;
  assign bus.resp_overflow = resp_overflow_q;
  assign busy              = (state != IDLE);

  // Logic and shift ops leave a stale overflow flag in the ALU.
  assign arith_op = (func_t'(alu_func) == FN_ADD) || (func_t'(alu_func) == FN_SUB);

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept) next_state = EXEC;
      EXEC:    next_state = DONE;
      DONE:    if (resp_take) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // NOTE: every register here is reset, including the held result, so an
  // aborted transaction can never leak a stale response after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_a           <= '0;
      alu_b           <= '0;
      alu_func        <= '0;
      grant_id        <= 1'b0;
      last_grant      <= 1'b1;
      resp_data_q     <= '0;
      resp_overflow_q <= 1'b0;
    end else begin
      if ((state == IDLE) && accept) begin
        alu_a    <= winner ? bus.req1_a    : bus.req0_a;
        alu_b    <= winner ? bus.req1_b    : bus.req0_b;
        alu_func <= winner ? bus.req1_func : bus.req0_func;
        grant_id <= winner;
      end
      if (state == EXEC) begin
        resp_data_q     <= alu_c;
        resp_overflow_q <= arith_op && alu_overflow;
      end
      if ((state == DONE) && resp_take) begin
        last_grant <= grant_id;
      end
    end
  end

  a_one_ready : assert property (@(posedge clk) disable iff (!reset_n)
    !(bus.req0_ready && bus.req1_ready));

  a_one_resp : assert property (@(posedge clk) disable iff (!reset_n)
    !(bus.resp0_valid && bus.resp1_valid));

  a_resp_hold : assert property (@(posedge clk) disable iff (!reset_n)
    ((state == DONE) && !resp_take) |=>
      ((state == DONE) && $stable(resp_data_q) && $stable(resp_overflow_q)
       && $stable(grant_id)));

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table of single ops plus hand-written
// contention, backpressure, idle-drop and mid-operation reset sequences.
module tb_alu_arbiter;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [W-1:0] alu_c;
  logic [2:0]   alu_func;
  logic         alu_overflow;
  logic         busy;
  logic         grant_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter_if #(.WORD_SIZE(W)) bus ();

  alu_arbiter #(.WORD_SIZE(W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus.slave),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_func     (alu_func),
    .alu_c        (alu_c),
    .alu_overflow (alu_overflow),
    .busy         (busy),
    .grant_id     (grant_id)
  );

  // External ALU model; non-arithmetic ops report a stale overflow of 1.
  always_comb begin
    logic [W-1:0] r;
    r            = '0;
    alu_overflow = 1'b1;
    case (alu_func)
      3'd0: begin
        r            = alu_a + alu_b;
        alu_overflow = (alu_a[W-1] == alu_b[W-1]) && (r[W-1] != alu_a[W-1]);
      end
      3'd1: begin
        r            = alu_a - alu_b;
        alu_overflow = (alu_a[W-1] != alu_b[W-1]) && (r[W-1] != alu_a[W-1]);
      end
      3'd2:    r = alu_a & alu_b;
      3'd3:    r = alu_a | alu_b;
      3'd4:    r = ~alu_a;
      3'd5:    r = -alu_a;
      3'd6:    r = {alu_a[W-2:0], 1'b0};
      default: r = {alu_a[W-1], alu_a[W-1:1]};
    endcase
    alu_c = r;
  end

  typedef struct {
    int         port;
    logic [2:0] func;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] data;
    logic       ovf;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int port, input logic v, input logic [2:0] f,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    if (port == 0) begin
      bus.req0_valid = v; bus.req0_func = f; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = v; bus.req1_func = f; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  task automatic set_resp_ready(input int port, input logic v);
    if (port == 0) bus.resp0_ready = v;
    else           bus.resp1_ready = v;
  endtask

  function automatic logic ready_of(input int port);
    return (port == 0) ? bus.req0_ready : bus.req1_ready;
  endfunction

  function automatic logic resp_valid_of(input int port);
    return (port == 0) ? bus.resp0_valid : bus.resp1_valid;
  endfunction

  // One uncontended transaction with exact-latency checks.
  task automatic run_op(input string tag, input vec_t v);
    @(negedge clk);
    drive(v.port, 1'b1, v.func, v.a, v.b);
    #1;
    check({tag, " ready"}, 32'(ready_of(v.port)), 32'd1);
    check({tag, " other ready"}, 32'(ready_of(1 - v.port)), 32'd0);
    @(posedge clk);
    #1;
    drive(v.port, 1'b0, 3'd0, '0, '0);
    check({tag, " busy exec"}, 32'(busy), 32'd1);
    check({tag, " alu_a exec"}, 32'(alu_a), 32'(v.a));
    check({tag, " early resp"}, 32'(resp_valid_of(v.port)), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check({tag, " resp valid"}, 32'(resp_valid_of(v.port)), 32'd1);
    check({tag, " other resp"}, 32'(resp_valid_of(1 - v.port)), 32'd0);
    check({tag, " data"}, 32'(bus.resp_data), 32'(v.data));
    check({tag, " overflow"}, 32'(bus.resp_overflow), 32'(v.ovf));
    check({tag, " grant_id"}, 32'(grant_id), 32'(v.port));
    set_resp_ready(v.port, 1'b1);
    @(posedge clk);
    #1;
    set_resp_ready(v.port, 1'b0);
    check({tag, " resp cleared"}, 32'(resp_valid_of(v.port)), 32'd0);
    check({tag, " busy idle"}, 32'(busy), 32'd0);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 3'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b1};
    vecs[1] = '{1, 3'd1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1};
    vecs[2] = '{1, 3'd6, 16'h4001, 16'h0000, 16'h8002, 1'b0};
    vecs[3] = '{0, 3'd5, 16'h0001, 16'h0000, 16'hFFFF, 1'b0};
    vecs[4] = '{0, 3'd4, 16'h00FF, 16'h0000, 16'hFF00, 1'b0};
    vecs[5] = '{1, 3'd3, 16'h1200, 16'h0034, 16'h1234, 1'b0};
    vecs[6] = '{0, 3'd0, 16'h0001, 16'h0002, 16'h0003, 1'b0};
    vecs[7] = '{1, 3'd1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0};
    vecs[8] = '{0, 3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b0};

    reset_n = 1'b0;
    drive(0, 1'b1, 3'd0, 16'h1111, 16'h2222);
    drive(1, 1'b1, 3'd0, 16'h3333, 16'h4444);
    bus.resp0_ready = 1'b0;
    bus.resp1_ready = 1'b0;

    // Reset state, with both valids high to prove ready is suppressed.
    @(negedge clk);
    check("rst req0_ready", 32'(bus.req0_ready), 32'd0);
    check("rst req1_ready", 32'(bus.req1_ready), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst grant_id", 32'(grant_id), 32'd0);
    check("rst resp valids", 32'({bus.resp1_valid, bus.resp0_valid}), 32'd0);
    check("rst alu regs", 32'({alu_func, alu_a | alu_b}), 32'd0);
    check("rst resp data/ovf", 32'({bus.resp_overflow, bus.resp_data}), 32'd0);
    drive(0, 1'b0, 3'd0, '0, '0);
    drive(1, 1'b0, 3'd0, '0, '0);
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) run_op($sformatf("vec%0d", i), vecs[i]);

    // Contention from reset: both held valid, responses consumed at once.
    apply_reset();
    bus.resp0_ready = 1'b1;
    bus.resp1_ready = 1'b1;
    drive(0, 1'b1, 3'd0, 16'h0010, 16'h0001);
    drive(1, 1'b1, 3'd2, 16'h00FF, 16'h0F0F);
    for (int i = 0; i < 4; i++) begin
      int exp_port;
      exp_port = i % 2;
      #1;
      check($sformatf("cont%0d ready", i), 32'(ready_of(exp_port)), 32'd1);
      check($sformatf("cont%0d other ready", i), 32'(ready_of(1 - exp_port)), 32'd0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("cont%0d resp valid", i), 32'(resp_valid_of(exp_port)), 32'd1);
      check($sformatf("cont%0d other resp", i), 32'(resp_valid_of(1 - exp_port)), 32'd0);
      check($sformatf("cont%0d grant_id", i), 32'(grant_id), 32'(exp_port));
      check($sformatf("cont%0d data", i), 32'(bus.resp_data),
            (exp_port == 0) ? 32'h0011 : 32'h000F);
      @(posedge clk);
      @(negedge clk);
    end
    drive(0, 1'b0, 3'd0, '0, '0);
    drive(1, 1'b0, 3'd0, '0, '0);
    bus.resp0_ready = 1'b0;
    bus.resp1_ready = 1'b0;

    // Backpressure: req0 result held while req1 waits unserved.
    @(negedge clk);
    drive(0, 1'b1, 3'd2, 16'hF0F0, 16'h0FF0);
    #1;
    check("bp req0_ready", 32'(bus.req0_ready), 32'd1);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 3'd0, '0, '0);
    drive(1, 1'b1, 3'd1, 16'h0005, 16'h0003);
    bus.resp1_ready = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp%0d resp0_valid", i), 32'(bus.resp0_valid), 32'd1);
      check($sformatf("bp%0d data", i), 32'(bus.resp_data), 32'h00F0);
      check($sformatf("bp%0d req1_ready", i), 32'(bus.req1_ready), 32'd0);
      check($sformatf("bp%0d resp1_valid", i), 32'(bus.resp1_valid), 32'd0);
    end
    bus.resp0_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp0_ready = 1'b0;
    check("bp idle busy", 32'(busy), 32'd0);
    check("bp req1_ready", 32'(bus.req1_ready), 32'd1);
    @(posedge clk);
    #1;
    drive(1, 1'b0, 3'd0, '0, '0);
    @(posedge clk);
    @(negedge clk);
    check("bp resp1_valid", 32'(bus.resp1_valid), 32'd1);
    check("bp resp1 data", 32'(bus.resp_data), 32'h0002);
    check("bp resp1 ovf", 32'(bus.resp_overflow), 32'd0);
    check("bp grant_id", 32'(grant_id), 32'd1);
    @(posedge clk);
    #1;
    bus.resp1_ready = 1'b0;
    check("bp resp1 consumed", 32'(bus.resp1_valid), 32'd0);

    // Valid dropped in IDLE before an edge: nothing is accepted.
    @(negedge clk);
    drive(1, 1'b1, 3'd3, 16'h00AA, 16'h0055);
    #1;
    check("drop req1_ready", 32'(bus.req1_ready), 32'd1);
    #1;
    drive(1, 1'b0, 3'd0, '0, '0);
    @(posedge clk);
    #1;
    check("drop busy", 32'(busy), 32'd0);

    // Reset during EXEC aborts the transaction.
    @(negedge clk);
    drive(0, 1'b1, 3'd7, 16'h8004, 16'h0000);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 3'd0, '0, '0);
    check("abort busy exec", 32'(busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort grant_id", 32'(grant_id), 32'd0);
    check("abort alu regs", 32'({alu_func, alu_a | alu_b}), 32'd0);
    check("abort resp data/ovf", 32'({bus.resp_overflow, bus.resp_data}), 32'd0);
    check("abort resp valids", 32'({bus.resp1_valid, bus.resp0_valid}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("abort%0d no resp", i),
            32'({busy, bus.resp1_valid, bus.resp0_valid}), 32'd0);
    end
    run_op("asr", '{0, 3'd7, 16'h8004, 16'h0000, 16'hC002, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
